ysyx_22040632_div_ctrl: RTL and testbench

YSYX_22040632_DIV_CTRL -- requirements
Module: ysyx_22040632_div_ctrl

---
 rtl/ysyx_22040632_div_pkg.sv | 20 ++
 rtl/ysyx_22040632_div_ctrl_if.sv | 27 ++
 rtl/ysyx_22040632_div_special.sv | 49 ++++
 rtl/ysyx_22040632_div_ctrl.sv | 133 +++++++++++++
 tb/tb_ysyx_22040632_div_ctrl.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ysyx_22040632_div_pkg.sv
// Shared definitions for the divider sequencing block: operand width,
// request opcode bit positions and the controller state encoding.
package ysyx_22040632_div_pkg;

  localparam int XLEN = 64;

  // req_op bit positions
  localparam int OP_UNS  = 0;  // 1 = unsigned divide
  localparam int OP_REM  = 1;  // 1 = return remainder instead of quotient
  localparam int OP_WORD = 2;  // 1 = 32-bit word operation, result sign-extended

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP,
    S_DRAIN
  } state_t;

endpackage

// File: rtl/ysyx_22040632_div_ctrl_if.sv
// Request/response bus between the pipeline and the divide controller.
// master = pipeline side, slave = controller side.
interface ysyx_22040632_div_ctrl_if
  import ysyx_22040632_div_pkg::*;
#(
  parameter int XLEN = ysyx_22040632_div_pkg::XLEN
);
  logic            req_valid;
  logic            req_ready;
  logic [2:0]      req_op;
  logic [XLEN-1:0] req_src1;
  logic [XLEN-1:0] req_src2;
  logic            flush;
  logic            resp_valid;
  logic            resp_ready;
  logic [XLEN-1:0] resp_data;

  modport master (
    output req_valid, req_op, req_src1, req_src2, flush, resp_ready,
    input  req_ready, resp_valid, resp_data
  );

  modport slave (
    input  req_valid, req_op, req_src1, req_src2, flush, resp_ready,
    output req_ready, resp_valid, resp_data
  );
endinterface

// File: rtl/ysyx_22040632_div_special.sv
// Combinational detection of divide-by-zero and signed overflow, with the
// architecturally defined quotient/remainder for those cases.
module ysyx_22040632_div_special
  import ysyx_22040632_div_pkg::*;
#(
  parameter int XLEN = ysyx_22040632_div_pkg::XLEN
) (
  input  logic [XLEN-1:0] src1,
  input  logic [XLEN-1:0] src2,
  input  logic [2:0]      op,
  output logic            is_special,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder
);

  logic            word;
  logic            uns;
  logic            div_zero;
  logic            overflow;
  logic [XLEN-1:0] min_val;
  logic [XLEN-1:0] src1_w;
  // quotient/remainder are both produced here, so the rem selector is not needed
  logic            unused_rem_bit;

  assign word           = op[OP_WORD];
  assign uns            = op[OP_UNS];
  assign unused_rem_bit = op[OP_REM];
  assign src1_w         = {{(XLEN-32){src1[31]}}, src1[31:0]};
  // most negative value, already sign-extended for word mode
  assign min_val        = word ? {{(XLEN-31){1'b1}}, 31'b0} : {1'b1, {(XLEN-1){1'b0}}};
  assign div_zero       = word ? (src2[31:0] == 32'd0) : (src2 == '0);
  assign overflow       = !uns && (word ? (src1[31:0] == 32'h8000_0000 && src2[31:0] == 32'hFFFF_FFFF)
                                        : (src1 == min_val && src2 == '1));
  assign is_special     = div_zero | overflow;

  // special-case results; divide-by-zero wins when both could apply
  always_comb begin
    quotient  = '0;
    remainder = '0;
    if (div_zero) begin
      quotient  = '1;
      remainder = word ? src1_w : src1;
    end else if (overflow) begin
      quotient  = min_val;
      remainder = '0;
    end
  end

endmodule

// File: rtl/ysyx_22040632_div_ctrl.sv
// Divide controller: accepts requests, short-circuits special cases and
// repeated operands via a single-entry result cache, otherwise sequences an
// external iterative divider and returns the selected quotient/remainder.
module ysyx_22040632_div_ctrl
  import ysyx_22040632_div_pkg::*;
#(
  parameter int XLEN = ysyx_22040632_div_pkg::XLEN
) (
  input  logic                         clk,
  input  logic                         rrst,
  ysyx_22040632_div_ctrl_if.slave      bus,
  output logic                         div_valid,
  input  logic                         div_ready,
  output logic [XLEN-1:0]              div_dividend,
  output logic [XLEN-1:0]              div_divisor,
  output logic                         div_divw,
  output logic                         div_signed,
  output logic                         div_flush,
  input  logic                         div_out_valid,
  input  logic [XLEN-1:0]              div_quotient,
  input  logic [XLEN-1:0]              div_remainder
);

  state_t          state_reg, state_next;
  logic [XLEN-1:0] src1_reg, src2_reg, result_reg;
  logic [2:0]      op_reg;

  logic            cache_valid_reg;
  logic [XLEN-1:0] cache_src1_reg, cache_src2_reg;
  logic            cache_word_reg, cache_uns_reg;
  logic [XLEN-1:0] cache_quot_reg, cache_rem_reg;

  logic            sp_is_special;
  logic [XLEN-1:0] sp_quot, sp_rem;
  logic            accept, cache_hit, fast_path, div_done;
  logic [XLEN-1:0] fast_result, done_quot, done_rem;

  ysyx_22040632_div_special #(.XLEN(XLEN)) u_special (
    .src1       (bus.req_src1),
    .src2       (bus.req_src2),
    .op         (bus.req_op),
    .is_special (sp_is_special),
    .quotient   (sp_quot),
    .remainder  (sp_rem)
  );

  assign accept    = (state_reg == S_IDLE) && bus.req_valid && !bus.flush;
  assign cache_hit = cache_valid_reg
                  && (bus.req_src1 == cache_src1_reg)
                  && (bus.req_src2 == cache_src2_reg)
                  && (bus.req_op[OP_WORD] == cache_word_reg)
                  && (bus.req_op[OP_UNS] == cache_uns_reg);
  assign fast_path = sp_is_special | cache_hit;

  // special cases take precedence over the cache; both resolve in one cycle
  assign fast_result = sp_is_special ? (bus.req_op[OP_REM] ? sp_rem : sp_quot)
                                     : (bus.req_op[OP_REM] ? cache_rem_reg : cache_quot_reg);

  // word results are sign-extended regardless of what the divider returns
  assign done_quot = op_reg[OP_WORD] ? {{(XLEN-32){div_quotient[31]}}, div_quotient[31:0]} : div_quotient;
  assign done_rem  = op_reg[OP_WORD] ? {{(XLEN-32){div_remainder[31]}}, div_remainder[31:0]} : div_remainder;
  assign div_done  = (state_reg == S_WAIT) && div_out_valid && !bus.flush;

  assign bus.req_ready  = (state_reg == S_IDLE);
  assign bus.resp_valid = (state_reg == S_RESP);
  assign bus.resp_data  = result_reg;
  assign div_valid      = (state_reg == S_ISSUE) && !bus.flush;
  assign div_flush      = (state_reg == S_WAIT) && bus.flush;
  assign div_dividend   = src1_reg;
  assign div_divisor    = src2_reg;
  assign div_divw       = op_reg[OP_WORD];
  assign div_signed     = !op_reg[OP_UNS];

  // state register
  always_ff @(posedge clk or posedge rrst) begin
    if (rrst) state_reg <= S_IDLE;
    else      state_reg <= state_next;
  end

  // next-state selection; flush always wins over progress
  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      S_IDLE:  if (accept) state_next = fast_path ? S_RESP : S_ISSUE;
      S_ISSUE: if (bus.flush) state_next = S_IDLE;
               else if (div_ready) state_next = S_WAIT;
      S_WAIT:  if (bus.flush) state_next = S_DRAIN;
               else if (div_out_valid) state_next = S_RESP;
      S_RESP:  if (bus.flush || bus.resp_ready) state_next = S_IDLE;
      S_DRAIN: if (div_ready && !div_out_valid) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // request latch and response register
  always_ff @(posedge clk or posedge rrst) begin
    if (rrst) begin
      src1_reg   <= '0;
      src2_reg   <= '0;
      op_reg     <= '0;
      result_reg <= '0;
    end else if (accept) begin
      src1_reg <= bus.req_src1;
      src2_reg <= bus.req_src2;
      op_reg   <= bus.req_op;
      if (fast_path) result_reg <= fast_result;
    end else if (div_done) begin
      result_reg <= op_reg[OP_REM] ? done_rem : done_quot;
    end
  end

  // result cache: refreshed only by a completed divider run
  always_ff @(posedge clk or posedge rrst) begin
    if (rrst) begin
      cache_valid_reg <= 1'b0;
      cache_src1_reg  <= '0;
      cache_src2_reg  <= '0;
      cache_word_reg  <= 1'b0;
      cache_uns_reg   <= 1'b0;
      cache_quot_reg  <= '0;
      cache_rem_reg   <= '0;
    end else if (div_done) begin
      cache_valid_reg <= 1'b1;
      cache_src1_reg  <= src1_reg;
      cache_src2_reg  <= src2_reg;
      cache_word_reg  <= op_reg[OP_WORD];
      cache_uns_reg   <= op_reg[OP_UNS];
      cache_quot_reg  <= done_quot;
      cache_rem_reg   <= done_rem;
    end
  end

endmodule

// File: tb/tb_ysyx_22040632_div_ctrl.sv
// Bench for the divide controller: behavioural divider with adjustable
// latency, table vectors, corner-case sequences and randomized requests.
module tb_ysyx_22040632_div_ctrl;
  import ysyx_22040632_div_pkg::*;

  logic clk = 1'b0;
  logic rrst = 1'b0;
  always #5 clk = ~clk;

  ysyx_22040632_div_ctrl_if #(.XLEN(64)) bus();

  logic        div_valid, div_ready, div_divw, div_signed, div_flush, div_out_valid;
  logic [63:0] div_dividend, div_divisor, div_quotient, div_remainder;

  ysyx_22040632_div_ctrl #(.XLEN(64)) dut (
    .clk           (clk),
    .rrst          (rrst),
    .bus           (bus),
    .div_valid     (div_valid),
    .div_ready     (div_ready),
    .div_dividend  (div_dividend),
    .div_divisor   (div_divisor),
    .div_divw      (div_divw),
    .div_signed    (div_signed),
    .div_flush     (div_flush),
    .div_out_valid (div_out_valid),
    .div_quotient  (div_quotient),
    .div_remainder (div_remainder)
  );

  int vectors = 0;
  int miscompares = 0;

  // expected result from the arithmetic rules alone
  function automatic logic [63:0] ref_result(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
    logic [31:0] a32, b32, q32, r32;
    logic [63:0] q64, r64;
    a32 = a[31:0];
    b32 = b[31:0];
    if (op[2]) begin
      if (b32 == 32'd0) begin q32 = '1; r32 = a32; end
      else if (!op[0] && a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) begin q32 = a32; r32 = 32'd0; end
      else if (op[0]) begin q32 = a32 / b32; r32 = a32 % b32; end
      else begin q32 = $signed(a32) / $signed(b32); r32 = $signed(a32) % $signed(b32); end
      return op[1] ? {{32{r32[31]}}, r32} : {{32{q32[31]}}, q32};
    end
    if (b == 64'd0) begin q64 = '1; r64 = a; end
    else if (!op[0] && a == 64'h8000_0000_0000_0000 && b == '1) begin q64 = a; r64 = 64'd0; end
    else if (op[0]) begin q64 = a / b; r64 = a % b; end
    else begin q64 = $signed(a) / $signed(b); r64 = $signed(a) % $signed(b); end
    return op[1] ? r64 : q64;
  endfunction

  // behavioural iterative divider
  logic        busy;
  int          cnt;
  int          mock_lat = 3;
  logic [63:0] m_a, m_b;
  logic        m_w, m_s;
  assign div_ready = ~busy;
  always @(posedge clk or posedge rrst) begin
    if (rrst) begin
      busy <= 1'b0; cnt <= 0; div_out_valid <= 1'b0;
      div_quotient <= '0; div_remainder <= '0;
      m_a <= '0; m_b <= '0; m_w <= 1'b0; m_s <= 1'b0;
    end else begin
      div_out_valid <= 1'b0;
      if (div_flush) busy <= 1'b0;
      else if (busy) begin
        if (cnt == 0) begin
          busy <= 1'b0;
          div_out_valid <= 1'b1;
          div_quotient  <= ref_result({m_w, 1'b0, ~m_s}, m_a, m_b);
          div_remainder <= ref_result({m_w, 1'b1, ~m_s}, m_a, m_b);
        end else cnt <= cnt - 1;
      end else if (div_valid) begin
        busy <= 1'b1; cnt <= mock_lat;
        m_a <= div_dividend; m_b <= div_divisor; m_w <= div_divw; m_s <= div_signed;
      end
    end
  end

  // model of the one-entry result cache
  logic        mc_valid = 1'b0;
  logic [63:0] mc_a, mc_b;
  logic        mc_w, mc_u;

  function automatic logic is_spec(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
    if (op[2]) return (b[31:0] == 32'd0) || (!op[0] && a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF);
    return (b == 64'd0) || (!op[0] && a == 64'h8000_0000_0000_0000 && b == '1);
  endfunction

  function automatic logic predict_fast(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
    return is_spec(op, a, b) || (mc_valid && mc_a == a && mc_b == b && mc_w == op[2] && mc_u == op[0]);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ".req_ready"}, bus.req_ready, 1'b1);
    check({tag, ".resp_valid"}, bus.resp_valid, 1'b0);
    check({tag, ".resp_data"}, bus.resp_data, 64'd0);
    check({tag, ".div_valid"}, div_valid, 1'b0);
    check({tag, ".div_flush"}, div_flush, 1'b0);
    check({tag, ".div_dividend"}, div_dividend, 64'd0);
    check({tag, ".div_divisor"}, div_divisor, 64'd0);
  endtask

  // one full request/response transaction
  task automatic run_txn(input string name, input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                         input int hold, input logic [63:0] exp, input logic exp_fast);
    int          lat;
    logic        ov_last;
    logic [63:0] d0;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_op = op; bus.req_src1 = a; bus.req_src2 = b; bus.resp_ready = 1'b0;
    lat = 0;
    while (!bus.req_ready && lat < 100) begin @(negedge clk); lat++; end
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    lat = 0; ov_last = 1'b0;
    while (!bus.resp_valid && lat < 300) begin
      ov_last = div_out_valid;
      @(posedge clk); #1;
      lat++;
    end
    check({name, ".resp_valid"}, bus.resp_valid, 1'b1);
    if (exp_fast) check({name, ".one_cycle"}, 64'(lat), 64'd0);
    else begin
      check({name, ".used_divider"}, lat != 0, 1'b1);
      check({name, ".after_div_out"}, ov_last, 1'b1);
    end
    check({name, ".data"}, bus.resp_data, exp);
    d0 = bus.resp_data;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check({name, ".hold_valid"}, bus.resp_valid, 1'b1);
      check({name, ".hold_data"}, bus.resp_data, d0);
      check({name, ".hold_req_ready"}, bus.req_ready, 1'b0);
    end
    @(negedge clk); bus.resp_ready = 1'b1;
    @(posedge clk); #1;
    bus.resp_ready = 1'b0;
    check({name, ".released"}, bus.resp_valid, 1'b0);
    if (!exp_fast) begin
      mc_valid = 1'b1; mc_a = a; mc_b = b; mc_w = op[2]; mc_u = op[0];
    end
    $display("txn %s op=%b a=%h b=%h data=%h lat=%0d", name, op, a, b, d0, lat);
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [63:0] a;
    logic [63:0] b;
    int          hold;
    logic [63:0] exp;
    logic        fast;
  } vec_t;

  vec_t tbl[11];

  initial begin
    logic        seen_resp;
    int          n;
    logic [2:0]  op;
    logic [63:0] a, b, pa, pb;

    tbl[0]  = '{3'b000, 64'd100, 64'd7, 0, 64'd14, 1'b0};
    tbl[1]  = '{3'b010, 64'd100, 64'd7, 0, 64'd2, 1'b1};
    tbl[2]  = '{3'b001, 64'd5, 64'd0, 0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1};
    tbl[3]  = '{3'b110, 64'h0000_0000_8000_0001, 64'd0, 1, 64'hFFFF_FFFF_8000_0001, 1'b1};
    tbl[4]  = '{3'b000, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 0, 64'h8000_0000_0000_0000, 1'b1};
    tbl[5]  = '{3'b110, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 0, 64'd0, 1'b1};
    tbl[6]  = '{3'b000, 64'd100, 64'd7, 0, 64'd14, 1'b1};
    tbl[7]  = '{3'b100, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 2, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0};
    tbl[8]  = '{3'b001, 64'd1000, 64'd10, 5, 64'd100, 1'b0};
    tbl[9]  = '{3'b111, 64'h0000_0001_0000_0007, 64'h0000_0001_0000_0003, 0, 64'd1, 1'b0};
    tbl[10] = '{3'b101, 64'h0000_0000_FFFF_FFFF, 64'd1, 0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0};

    bus.req_valid = 1'b0; bus.req_op = '0; bus.req_src1 = '0; bus.req_src2 = '0;
    bus.flush = 1'b0; bus.resp_ready = 1'b0;

    // asynchronous reset before any clock edge
    #1 rrst = 1'b1;
    #2 check_reset_outputs("reset");
    repeat (2) @(negedge clk);
    rrst = 1'b0;

    for (int i = 0; i < 11; i++)
      run_txn($sformatf("vec%0d", i), tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].hold, tbl[i].exp, tbl[i].fast);

    // flush while waiting on the divider: pulse to divider, no response
    mock_lat = 30;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_op = 3'b000; bus.req_src1 = 64'd1000; bus.req_src2 = 64'd3;
    @(posedge clk); #1 bus.req_valid = 1'b0;
    repeat (11) @(posedge clk);
    @(negedge clk); bus.flush = 1'b1;
    #1 check("wait_flush.div_flush", div_flush, 1'b1);
    check("wait_flush.no_resp", bus.resp_valid, 1'b0);
    @(negedge clk); bus.flush = 1'b0;
    check("wait_flush.pulse_once", div_flush, 1'b0);
    seen_resp = 1'b0; n = 0;
    while (!bus.req_ready && n < 50) begin
      @(negedge clk); n++;
      if (bus.resp_valid) seen_resp = 1'b1;
    end
    check("wait_flush.back_idle", bus.req_ready, 1'b1);
    check("wait_flush.resp_dropped", seen_resp, 1'b0);
    mock_lat = 3;
    run_txn("div1000_3_after_flush", 3'b000, 64'd1000, 64'd3, 0, 64'd333, 1'b0);

    // flush in IDLE blocks acceptance
    @(negedge clk);
    bus.req_valid = 1'b1; bus.flush = 1'b1; bus.req_op = 3'b001; bus.req_src1 = 64'd5; bus.req_src2 = 64'd0;
    @(posedge clk); #1;
    check("idle_flush.req_ready", bus.req_ready, 1'b1);
    check("idle_flush.no_resp", bus.resp_valid, 1'b0);
    @(negedge clk); bus.req_valid = 1'b0; bus.flush = 1'b0;

    // flush in RESP drops the response
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_op = 3'b001; bus.req_src1 = 64'd5; bus.req_src2 = 64'd0;
    @(posedge clk); #1 bus.req_valid = 1'b0;
    check("resp_flush.resp_up", bus.resp_valid, 1'b1);
    @(negedge clk); bus.flush = 1'b1;
    @(posedge clk); #1;
    check("resp_flush.dropped", bus.resp_valid, 1'b0);
    check("resp_flush.idle", bus.req_ready, 1'b1);
    @(negedge clk); bus.flush = 1'b0;

    // reset in the middle of a divider run, then the cache must be empty
    mock_lat = 30;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_op = 3'b000; bus.req_src1 = 64'd1000; bus.req_src2 = 64'd7;
    @(posedge clk); #1 bus.req_valid = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk); rrst = 1'b1;
    #1 check_reset_outputs("mid_wait_reset");
    @(negedge clk); rrst = 1'b0;
    mc_valid = 1'b0;
    mock_lat = 3;
    run_txn("rem1000_3_after_reset", 3'b010, 64'd1000, 64'd3, 0, 64'd1, 1'b0);

    // randomized requests against the reference model
    pa = 64'd1; pb = 64'd1;
    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(0, 7));
      if (i > 0 && $urandom_range(0, 2) == 0) begin
        a = pa; b = pb;
      end else begin
        case ($urandom_range(0, 3))
          0: a = {$urandom, $urandom};
          1: a = 64'($urandom_range(0, 1000));
          2: a = 64'h8000_0000_0000_0000;
          default: a = 64'h0000_0000_8000_0000;
        endcase
        case ($urandom_range(0, 3))
          0: b = 64'd0;
          1: b = '1;
          2: b = 64'($urandom_range(1, 20));
          default: b = {$urandom, $urandom};
        endcase
      end
      mock_lat = $urandom_range(0, 5);
      run_txn($sformatf("rnd%0d", i), op, a, b, $urandom_range(0, 2), ref_result(op, a, b), predict_fast(op, a, b));
      pa = a; pb = b;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
